tqvp_bus_arbiter: RTL and testbench

TQVP_BUS_ARBITER -- requirements
Module: tqvp_bus_arbiter

---
 rtl/tqvp_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_tqvp_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_bus_arbiter.sv
// Round-robin arbiter for two requesters onto one peripheral register bus; gnt one cycle after req is sampled.
// Writes occupy ACCESS only; reads add READ_LAT cycles, then rvalid. Requests wait (level-held) while busy.
module tqvp_bus_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [3:0] p_address,
  output logic [7:0] p_data_in,
  output logic       p_data_write,
  input  logic [7:0] p_data_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic       win;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    p_data_write = 1'b0;
    // last_q names the previous winner, so contention goes to the other side
    win          = (req0 && req1) ? ~last_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          sel_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        gnt0         = ~sel_q;
        gnt1         = sel_q;
        p_data_write = we_q;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
          cnt_d   = CNT_LOAD;
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          if (sel_q) begin
            rdata1_d  = p_data_out;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = p_data_out;
            rvalid0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 4'd0;
      wdata_q   <= 8'd0;
      cnt_q     <= 3'd0;
      rdata0_q  <= 8'd0;
      rdata1_q  <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign p_address = addr_q;
  assign p_data_in = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Bench for tqvp_bus_arbiter: directed scenarios then random traffic against a transaction-schedule model.
module tb_tqvp_bus_arbiter;

  localparam int LAT = 4;
  localparam int NC  = 2600;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_v  [2];
  logic       we_v   [2];
  logic [3:0] addr_v [2];
  logic [7:0] wd_v   [2];
  logic       gnt0, gnt1, rvalid0, rvalid1, p_data_write, busy;
  logic [7:0] rdata0, rdata1, p_data_in, p_data_out;
  logic [3:0] p_address;
  logic [7:0] periph_mem [16];

  assign p_data_out = periph_mem[p_address];

  always #5 clk = ~clk;

  tqvp_bus_arbiter #(.READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .we0(we_v[0]), .we1(we_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wd_v[0]), .wdata1(wd_v[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .p_address(p_address), .p_data_in(p_data_in),
    .p_data_write(p_data_write), .p_data_out(p_data_out),
    .busy(busy)
  );

  // Expected per-cycle outputs, filled in when a transaction is issued
  bit         e_gnt  [2][NC];
  bit         e_rv   [2][NC];
  bit         e_rset [2][NC];
  logic [7:0] e_rval [2][NC];
  bit         e_busy [NC];
  bit         e_pwr  [NC];
  bit         e_aset [NC];
  logic [3:0] e_addr [NC];
  logic [7:0] e_wd   [NC];
  logic [7:0] model_mem [16];
  logic [7:0] cur_rd [2];
  logic [3:0] cur_addr;
  logic [7:0] cur_wd;
  int         free_at;
  bit         last;
  bit         armed;
  int         k;
  int         n_checks;
  int         n_fail;
  logic       s_gnt0, s_gnt1, s_rv0, s_rv1, s_pwr, s_busy;
  logic [7:0] s_rd0, s_rd1, s_wd;
  logic [3:0] s_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = k + 1; j < NC; j++) begin
      e_gnt[0][j] = 0; e_gnt[1][j] = 0; e_rv[0][j] = 0; e_rv[1][j] = 0;
      e_rset[0][j] = 0; e_rset[1][j] = 0;
      e_busy[j] = 0; e_pwr[j] = 0; e_aset[j] = 0;
    end
    e_aset[k+1] = 1; e_addr[k+1] = 4'd0; e_wd[k+1] = 8'd0;
    for (int n = 0; n < 2; n++) begin
      e_rset[n][k+1] = 1;
      e_rval[n][k+1] = 8'd0;
    end
    free_at = k + 1;
    last    = 1'b1;
  endtask

  task automatic model_issue();
    int w;
    if (req_v[0] && req_v[1]) w = last ? 0 : 1;
    else                      w = req_v[1] ? 1 : 0;
    last = (w == 1);
    e_gnt[w][k+1] = 1;
    e_busy[k+1]   = 1;
    e_aset[k+1]   = 1;
    e_addr[k+1]   = addr_v[w];
    e_wd[k+1]     = wd_v[w];
    if (we_v[w]) begin
      e_pwr[k+1] = 1;
      model_mem[addr_v[w]] = wd_v[w];
      free_at = k + 2;
    end else begin
      for (int j = k + 2; j <= k + 1 + LAT; j++) e_busy[j] = 1;
      e_rv[w][k+2+LAT]   = 1;
      e_rset[w][k+2+LAT] = 1;
      e_rval[w][k+2+LAT] = model_mem[addr_v[w]];
      free_at = k + 2 + LAT;
    end
  endtask

  // Inputs for cycle k are already driven; sample at the falling edge, then advance
  task automatic run_cycle();
    #4;
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1;
    s_rd0 = rdata0; s_rd1 = rdata1; s_addr = p_address; s_wd = p_data_in;
    s_pwr = p_data_write; s_busy = busy;
    if (armed) begin
      if (e_aset[k]) begin cur_addr = e_addr[k]; cur_wd = e_wd[k]; end
      for (int n = 0; n < 2; n++) if (e_rset[n][k]) cur_rd[n] = e_rval[n][k];
      check_eq("gnt0", s_gnt0, e_gnt[0][k]);
      check_eq("gnt1", s_gnt1, e_gnt[1][k]);
      check_eq("rvalid0", s_rv0, e_rv[0][k]);
      check_eq("rvalid1", s_rv1, e_rv[1][k]);
      check_eq("busy", s_busy, e_busy[k]);
      check_eq("p_data_write", s_pwr, e_pwr[k]);
      check_eq("rdata0", s_rd0, cur_rd[0]);
      check_eq("rdata1", s_rd1, cur_rd[1]);
      check_eq("p_address", s_addr, cur_addr);
      check_eq("p_data_in", s_wd, cur_wd);
    end
    if (s_pwr === 1'b1 && !$isunknown(s_addr)) periph_mem[s_addr] = s_wd;
    if (rst) begin
      model_reset();
      armed = 1'b1;
    end else if (k >= free_at && (req_v[0] || req_v[1])) begin
      model_issue();
    end
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic set_req(input int n, input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    req_v[n] = r; we_v[n] = w; addr_v[n] = a; wd_v[n] = d;
  endtask

  task automatic rand_drive();
    for (int n = 0; n < 2; n++) begin
      if ((k > 0 && e_gnt[n][k-1]) || !req_v[n]) begin
        if ($urandom_range(99) < 45)
          set_req(n, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom));
        else
          req_v[n] = 1'b0;
      end
    end
    rst = ($urandom_range(249) == 0);
  endtask

  initial begin
    int t;
    n_checks = 0; n_fail = 0; k = 0; armed = 0; free_at = 0; last = 1;
    cur_rd[0] = 0; cur_rd[1] = 0; cur_addr = 0; cur_wd = 0;
    for (int i = 0; i < 16; i++) begin
      periph_mem[i] = 8'(i * 37 + 11);
      model_mem[i]  = 8'(i * 37 + 11);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_cycle();
    run_cycle();
    rst = 1'b0;

    // Single write from requester 0
    set_req(0, 1, 1, 4'h3, 8'hA5);
    run_cycle();
    req_v[0] = 1'b0;
    run_cycle();
    check_eq("wr_gnt0", s_gnt0, 1);
    check_eq("wr_pwr", s_pwr, 1);
    check_eq("wr_addr", s_addr, 4'h3);
    check_eq("wr_data", s_wd, 8'hA5);
    run_cycle();
    check_eq("wr_idle_after", s_busy, 0);

    // Store 5C at address 7, then read it back through requester 1
    set_req(0, 1, 1, 4'h7, 8'h5C);
    run_cycle();
    req_v[0] = 1'b0;
    run_cycle();
    run_cycle();
    set_req(1, 1, 0, 4'h7, 8'h00);
    run_cycle();
    req_v[1] = 1'b0;
    for (int d = 1; d <= LAT + 2; d++) begin
      run_cycle();
      if (d == 1) check_eq("rd_gnt1", s_gnt1, 1);
      if (d >= 1 && d <= LAT + 1) begin
        check_eq("rd_busy", s_busy, 1);
        check_eq("rd_addr_hold", s_addr, 4'h7);
      end
      if (d == LAT + 1) check_eq("rd_rv_early", s_rv1, 0);
      if (d == LAT + 2) begin
        check_eq("rd_rvalid1", s_rv1, 1);
        check_eq("rd_rdata1", s_rd1, 8'h5C);
        check_eq("rd_idle", s_busy, 0);
      end
    end

    // Both requesters held high after reset: grants alternate starting with 0
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    for (int d = 1; d <= 8; d++) begin
      set_req(0, 1, 1, 4'(d), 8'(d * 3));
      set_req(1, 1, 1, 4'(d + 8), 8'(d * 5));
      run_cycle();
      check_eq("rr_gnt0", s_gnt0, (d % 2 == 0) && ((d / 2) % 2 == 1));
      check_eq("rr_gnt1", s_gnt1, (d % 2 == 0) && ((d / 2) % 2 == 0));
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    run_cycle();
    run_cycle();

    // Reset in the middle of a read discards it
    set_req(1, 1, 0, 4'h2, 8'h00);
    run_cycle();
    req_v[1] = 1'b0;
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycle();
    check_eq("rstrd_busy", s_busy, 0);
    check_eq("rstrd_rdata1", s_rd1, 0);
    check_eq("rstrd_addr", s_addr, 0);
    for (t = 0; t < LAT + 3; t++) begin
      run_cycle();
      check_eq("rstrd_no_rvalid", s_rv1, 0);
    end

    while (k < NC - 20) begin
      rand_drive();
      run_cycle();
    end
    rst = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    for (t = 0; t < LAT + 4; t++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
